// File: rtl/dual_rail_minterm_sequencer_pkg.sv
// Shared types and helpers for the dual-rail minterm sequencer.
// Build option GRAY_SWEEP_EN selects reflected Gray sweep order in stepToIndex.
package dual_rail_minterm_sequencer_pkg;

  localparam int NUM_VARS     = 4;
  localparam int NUM_MINTERMS = 16;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } seq_state_e;

  // The sweep step always counts 0..15; only the minterm presented on the rails changes order.
  function automatic logic [NUM_VARS-1:0] stepToIndex(input logic [NUM_VARS-1:0] step);
`ifdef GRAY_SWEEP_EN
    return step ^ (step >> 1);
`else
    return step;
`endif
  endfunction

endpackage

// File: rtl/dual_rail_minterm_sequencer_if.sv
// Stimulus/response bundle between the sequencer (slave) and whoever commands it and
// hosts the downstream function block (master).
interface dual_rail_minterm_sequencer_if;

  logic                                                     start;
  logic                                                     manual_load;
  logic [dual_rail_minterm_sequencer_pkg::NUM_VARS-1:0]     manual_val;
  logic                                                     f_in;
  logic                                                     a;
  logic                                                     b;
  logic                                                     c;
  logic                                                     d;
  logic                                                     not_a;
  logic                                                     not_b;
  logic                                                     not_c;
  logic                                                     not_d;
  logic [dual_rail_minterm_sequencer_pkg::NUM_VARS-1:0]     index;
  logic                                                     busy;
  logic                                                     done;
  logic [dual_rail_minterm_sequencer_pkg::NUM_MINTERMS-1:0] truth_table;

  modport master (
    output start, manual_load, manual_val, f_in,
    input  a, b, c, d, not_a, not_b, not_c, not_d, index, busy, done, truth_table
  );

  modport slave (
    input  start, manual_load, manual_val, f_in,
    output a, b, c, d, not_a, not_b, not_c, not_d, index, busy, done, truth_table
  );

endinterface

// File: rtl/dual_rail_minterm_sequencer_hold_timer.sv
// Per-minterm hold timer: 8-bit down-counter reloaded at the start of each minterm,
// flagging the capture cycle and the last hold cycle.
module minterm_hold_timer #(
  parameter int HOLD_CYCLES   = 20,
  parameter int SAMPLE_SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic active_i,
  output logic sample_strobe_o,
  output logic expire_o
);

  // Count holds the number of hold cycles still to follow the current one.
  localparam logic [7:0] LOAD_VAL   = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] SAMPLE_VAL = 8'(SAMPLE_SETTLE - 1);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = LOAD_VAL;
    end else if (active_i && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign sample_strobe_o = active_i && (count_q == SAMPLE_VAL);
  assign expire_o        = active_i && (count_q == 8'd0);

endmodule

// File: rtl/dual_rail_minterm_sequencer.sv
// Sweeps all 16 minterms onto dual-rail outputs and captures the returned function as a
// truth table; also offers manual single-minterm drive. Sweep order set by GRAY_SWEEP_EN.
module dual_rail_minterm_sequencer
  import dual_rail_minterm_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES   = 20,
  parameter int SAMPLE_SETTLE = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  dual_rail_minterm_sequencer_if.slave  bus
);

  localparam logic [NUM_VARS-1:0] LAST_STEP = NUM_VARS'(NUM_MINTERMS - 1);

  seq_state_e              state_q, state_d;
  logic [NUM_VARS-1:0]     step_q, step_d;
  logic [NUM_VARS-1:0]     index_q, index_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [NUM_MINTERMS-1:0] truthTable_q, truthTable_d;
  logic                    timerLoad;
  logic                    timerActive;
  logic                    sampleStrobe;
  logic                    holdExpire;

  assign timerActive = (state_q == DRIVE);

  minterm_hold_timer #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .SAMPLE_SETTLE (SAMPLE_SETTLE)
  ) u_hold_timer (
    .clk             (clk),
    .rst             (rst),
    .load_i          (timerLoad),
    .active_i        (timerActive),
    .sample_strobe_o (sampleStrobe),
    .expire_o        (holdExpire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = DRIVE;
      DRIVE:   if (holdExpire && (step_q == LAST_STEP)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags are derived from the upcoming state so they line up with it once registered.
  always_comb begin
    step_d       = step_q;
    index_d      = index_q;
    truthTable_d = truthTable_q;
    timerLoad    = 1'b0;
    busy_d       = (state_d == DRIVE);
    done_d       = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          truthTable_d = '0;
          step_d       = '0;
          index_d      = stepToIndex('0);
          timerLoad    = 1'b1;
        end else if (bus.manual_load) begin
          index_d = bus.manual_val;
        end
      end
      DRIVE: begin
        if (sampleStrobe) begin
          truthTable_d[index_q] = bus.f_in;
        end
        if (holdExpire && (step_q != LAST_STEP)) begin
          step_d    = step_q + 1'b1;
          index_d   = stepToIndex(step_q + 1'b1);
          timerLoad = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q       <= '0;
      index_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      truthTable_q <= '0;
    end else begin
      step_q       <= step_d;
      index_q      <= index_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      truthTable_q <= truthTable_d;
    end
  end

  // Both rails come from the same index register, so they can never agree.
  assign bus.a           = index_q[3];
  assign bus.b           = index_q[2];
  assign bus.c           = index_q[1];
  assign bus.d           = index_q[0];
  assign bus.not_a       = ~index_q[3];
  assign bus.not_b       = ~index_q[2];
  assign bus.not_c       = ~index_q[1];
  assign bus.not_d       = ~index_q[0];
  assign bus.index       = index_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.truth_table = truthTable_q;

endmodule

// File: tb/tb_dual_rail_minterm_sequencer.sv
// Scoreboard bench for dual_rail_minterm_sequencer; define GRAY_SWEEP_EN for both RTL and
// bench to exercise the Gray-order sweep.
module tb_dual_rail_minterm_sequencer;

  localparam int HOLD         = 20;
  localparam int SHORT_HOLD   = 2;
  localparam int SWEEP_CYCLES = 16 * HOLD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          edgeCnt = 0;
  int          total = 0;
  int          bad = 0;
  int          funcSel = 0;
  logic [15:0] lastTable = 16'h0;
  logic [15:0] ttQueue[$];
  logic [3:0]  idxQueue[$];

  always #5 clk = ~clk;
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  dual_rail_minterm_sequencer_if seqIf();
  dual_rail_minterm_sequencer_if shortIf();

  dual_rail_minterm_sequencer #(
    .HOLD_CYCLES   (HOLD),
    .SAMPLE_SETTLE (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (seqIf)
  );

  dual_rail_minterm_sequencer #(
    .HOLD_CYCLES   (SHORT_HOLD),
    .SAMPLE_SETTLE (1)
  ) dutShort (
    .clk (clk),
    .rst (rst),
    .bus (shortIf)
  );

  // Stand-in for the downstream function block: 0 selects a&b, otherwise a^b^c^d.
  function automatic logic modelFunc(input int sel, input logic [3:0] m);
    if (sel == 0) return m[3] & m[2];
    return ^m;
  endfunction

  function automatic logic [3:0] expectedIndex(input int s);
    logic [3:0] st;
    st = 4'(s);
`ifdef GRAY_SWEEP_EN
    return st ^ (st >> 1);
`else
    return st;
`endif
  endfunction

  assign seqIf.f_in   = modelFunc(funcSel, {seqIf.a, seqIf.b, seqIf.c, seqIf.d});
  assign shortIf.f_in = shortIf.a & shortIf.b;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic checkRails(input string tag);
    checkOutput(tag, 32'({seqIf.a, seqIf.b, seqIf.c, seqIf.d} ^
                         {seqIf.not_a, seqIf.not_b, seqIf.not_c, seqIf.not_d}), 32'hF);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".rails"}, 32'({seqIf.a, seqIf.b, seqIf.c, seqIf.d,
                 seqIf.not_a, seqIf.not_b, seqIf.not_c, seqIf.not_d}), 32'h0F);
    checkOutput({tag, ".index"}, 32'(seqIf.index), 32'h0);
    checkOutput({tag, ".busy"}, 32'(seqIf.busy), 32'h0);
    checkOutput({tag, ".done"}, 32'(seqIf.done), 32'h0);
    checkOutput({tag, ".table"}, 32'(seqIf.truth_table), 32'h0);
  endtask

  // Called just after a negedge while the DUT is idle; that cycle is cycle 0 of the sweep.
  task automatic applyStimulus(input int sel, input int resetAt, input int restartAt);
    logic [15:0] tt;
    logic [15:0] expTable;
    logic [3:0]  expIdx;
    logic [3:0]  prevIdx;
    int          base;
    int          k;
    bit          sawDone;
    prevIdx = 4'h0;
    sawDone = 1'b0;
    funcSel = sel;
    for (int m = 0; m < 16; m++) tt[m] = modelFunc(sel, 4'(m));
    ttQueue.push_back(tt);
    for (int s = 0; s < 16; s++) idxQueue.push_back(expectedIndex(s));
    seqIf.start = 1'b1;
    base = edgeCnt;
    for (int iter = 0; (iter < SWEEP_CYCLES + 10) && !sawDone; iter++) begin
      @(negedge clk);
      k = edgeCnt - base;
      seqIf.start = (k == restartAt);
      checkRails("railComplement");
      checkOutput("busy", 32'(seqIf.busy), 32'((k >= 1) && (k <= SWEEP_CYCLES)));
      if ((k >= 1) && (k <= SWEEP_CYCLES) && (((k - 1) % HOLD) == 0)) begin
        if (idxQueue.size() == 0) begin
          checkOutput("indexUnderflow", 32'h1, 32'h0);
        end else begin
          expIdx = idxQueue.pop_front();
          checkOutput("index", 32'(seqIf.index), 32'(expIdx));
`ifdef GRAY_SWEEP_EN
          if (k > 1) checkOutput("grayToggle", 32'($countones(seqIf.index ^ prevIdx)), 32'h1);
`endif
          prevIdx = seqIf.index;
        end
      end
      if (k == resetAt) begin
        rst = 1'b1;
        @(negedge clk);
        checkResetValues("midReset");
        rst = 1'b0;
        ttQueue.delete();
        idxQueue.delete();
        lastTable = 16'h0;
        @(negedge clk);
        return;
      end
      if (seqIf.done) begin
        sawDone = 1'b1;
        checkOutput("doneCycle", 32'(k), 32'(SWEEP_CYCLES + 1));
        if (ttQueue.size() == 0) begin
          checkOutput("tableUnderflow", 32'h1, 32'h0);
        end else begin
          expTable = ttQueue.pop_front();
          checkOutput("truthTable", 32'(seqIf.truth_table), 32'(expTable));
          lastTable = expTable;
        end
      end
    end
    seqIf.start = 1'b0;
    if (!sawDone) checkOutput("doneTimeout", 32'h0, 32'h1);
    @(negedge clk);
    checkOutput("donePulseWidth", 32'(seqIf.done), 32'h0);
    checkOutput("tableHold", 32'(seqIf.truth_table), 32'(lastTable));
    checkOutput("lastMintermHeld", 32'(seqIf.index), 32'(expectedIndex(15)));
  endtask

  task automatic applyManual(input logic [3:0] val);
    seqIf.manual_val  = val;
    seqIf.manual_load = 1'b1;
    @(negedge clk);
    checkOutput("manualRails", 32'({seqIf.a, seqIf.b, seqIf.c, seqIf.d,
                 seqIf.not_a, seqIf.not_b, seqIf.not_c, seqIf.not_d}), 32'({val, ~val}));
    checkOutput("manualIndex", 32'(seqIf.index), 32'(val));
    checkOutput("manualTable", 32'(seqIf.truth_table), 32'(lastTable));
    checkOutput("manualBusy", 32'(seqIf.busy), 32'h0);
    seqIf.manual_load = 1'b0;
    seqIf.manual_val  = 4'h0;
    @(negedge clk);
    checkOutput("idleHold", 32'(seqIf.index), 32'(val));
  endtask

  task automatic applyShortSweep();
    int  base;
    int  k;
    bit  sawDone;
    sawDone = 1'b0;
    shortIf.start = 1'b1;
    base = edgeCnt;
    for (int iter = 0; (iter < 16 * SHORT_HOLD + 10) && !sawDone; iter++) begin
      @(negedge clk);
      k = edgeCnt - base;
      shortIf.start = 1'b0;
      if (shortIf.done) begin
        sawDone = 1'b1;
        checkOutput("shortDoneCycle", 32'(k), 32'(16 * SHORT_HOLD + 1));
        checkOutput("shortTable", 32'(shortIf.truth_table), 32'hF000);
      end
    end
    if (!sawDone) checkOutput("shortDoneTimeout", 32'h0, 32'h1);
  endtask

  initial begin
    seqIf.start         = 1'b0;
    seqIf.manual_load   = 1'b0;
    seqIf.manual_val    = 4'h0;
    shortIf.start       = 1'b0;
    shortIf.manual_load = 1'b0;
    shortIf.manual_val  = 4'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(0, -1, -1);
    applyStimulus(1, -1, 50);
    applyStimulus(1, 100, -1);
    applyStimulus(1, -1, -1);

    applyManual(4'b1010);
    seqIf.manual_load = 1'b1;
    seqIf.manual_val  = 4'b0111;
    applyStimulus(0, -1, -1);
    seqIf.manual_load = 1'b0;
    seqIf.manual_val  = 4'h0;
    @(negedge clk);

    applyShortSweep();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
